// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave emulating the PmodJSTK joystick.
// Answers each 5-byte frame with a snapshot of x_pos, y_pos and buttons. It also
// decodes the master's first byte into two LED bits.
// Build option: define JSTK_RESP_TRISTATE_EN to release miso (1'bz) whenever the
// block is not in the middle of a frame (WAIT, IDLE, reset).
module jstk_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic [1:0] leds,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    localparam logic [5:0] FRAME_BITS = 6'd40;

    // Synchronizer chains, plus one extra flop per line for edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;

    state_e      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [39:0] tx_sh_q, tx_sh_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [1:0]  leds_q, leds_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic miso_act;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;

    // Shift the raw pins into their synchronizers and remember last synced value.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
    end

    // Frame FSM: snapshot on ss fall, shift on sclk edges, report on ss rise.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        tx_sh_d      = tx_sh_q;
        cmd_d        = cmd_q;
        leds_d       = leds_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                // Only start listening once ss is seen idle, so a frame already
                // in flight at reset release is never joined half-way.
                if (ss_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    tx_sh_d   = {x_pos[7:0], 6'b0, x_pos[9:8],
                                 y_pos[7:0], 6'b0, y_pos[9:8],
                                 5'b0, buttons};
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    // ss rise takes priority over any sclk edge seen this cycle.
                    state_d = ST_IDLE;
                    if (bit_cnt_q == FRAME_BITS) begin
                        frame_done_d = 1'b1;
                        if (cmd_q[7:2] == 6'b100000) leds_d = cmd_q[1:0];
                    end else if (bit_cnt_q != 6'd0) begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    if (sclk_rise && bit_cnt_q < FRAME_BITS) begin
                        if (bit_cnt_q < 6'd8) cmd_d = {cmd_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                    if (sclk_fall) tx_sh_d = {tx_sh_q[38:0], 1'b0};
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sclk_sync_q  <= '0;
            ss_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sclk_prev_q  <= 1'b0;
            ss_prev_q    <= 1'b0;
            state_q      <= ST_WAIT;
            bit_cnt_q    <= '0;
            tx_sh_q      <= '0;
            cmd_q        <= '0;
            leds_q       <= 2'b00;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            ss_sync_q    <= ss_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            ss_prev_q    <= ss_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_sh_q      <= tx_sh_d;
            cmd_q        <= cmd_d;
            leds_q       <= leds_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Past bit 40 the line is held low, so overrun clocks read back zeros.
    assign miso_act = (bit_cnt_q < FRAME_BITS) ? tx_sh_q[39] : 1'b0;

`ifdef JSTK_RESP_TRISTATE_EN
    assign miso = (state_q == ST_ACTIVE) ? miso_act : 1'bz;
`else
    assign miso = (state_q == ST_ACTIVE) ? miso_act : 1'b0;
`endif

    assign leds       = leds_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: a mode-0 SPI master at clk/16 plus a
// vector table of frames, and hand sequences for snapshot and mid-frame reset.
module tb_jstk_spi_responder;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [2:0] buttons = '0;
    logic       sclk = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [1:0] leds;
    logic       frame_done;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    jstk_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .clr_n(clr_n), .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
        .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso), .leds(leds),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

`ifdef JSTK_RESP_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
        logic [7:0]  cmd;
        int          nbits;
        logic [39:0] exp_frame;
        logic [1:0]  exp_leds;
        int          exp_done;
        int          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Half an SCLK period, leaving the bench 1 ns past a clk edge.
    task automatic hw();
        repeat (8) @(posedge clk);
        #1;
    endtask

    // One SPI frame. ev_kind 1 changes x_pos, ev_kind 2 pulses reset, both just
    // before bit ev_bit is presented.
    task automatic frame(input int n, input logic [7:0] c, input int ev_bit,
                         input int ev_kind, output logic [47:0] rx);
        rx = '0;
        ss = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == ev_bit && ev_kind == 1) x_pos = 10'h3FF;
            if (i == ev_bit && ev_kind == 2) begin
                clr_n = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_miso", {47'b0, miso}, {47'b0, MISO_IDLE});
                chk("rst_leds", {46'b0, leds}, 48'd0);
                clr_n = 1'b1;
            end
            mosi = (i < 8) ? c[7-i] : 1'b0;
            hw();
            sclk = 1'b1;
            rx = {rx[46:0], miso};
            hw();
            sclk = 1'b0;
        end
        hw();
        ss = 1'b1;
        hw();
        hw();
    endtask

    task automatic run_vec(input string name, input vec_t v);
        logic [47:0] rx, exp;
        int d0, e0;
        x_pos = v.x; y_pos = v.y; buttons = v.btn;
        d0 = done_cnt; e0 = err_cnt;
        frame(v.nbits, v.cmd, -1, 0, rx);
        if (v.nbits <= 40) exp = {8'b0, v.exp_frame} >> (40 - v.nbits);
        else exp = {8'b0, v.exp_frame} << (v.nbits - 40);
        chk({name, "_data"}, rx, exp);
        chk({name, "_leds"}, {46'b0, leds}, {46'b0, v.exp_leds});
        chk({name, "_done"}, 48'(done_cnt - d0), 48'(v.exp_done));
        chk({name, "_err"},  48'(err_cnt - e0), 48'(v.exp_err));
    endtask

    initial begin
        vec_t vt[5];
        logic [47:0] rx;
        int d0, e0;

        vt[0] = '{10'h2A5, 10'h13C, 3'b101, 8'h81, 40, 40'hA5023C0105, 2'b01, 1, 0};
        vt[1] = '{10'h2A5, 10'h13C, 3'b101, 8'h43, 40, 40'hA5023C0105, 2'b01, 1, 0};
        vt[2] = '{10'h2A5, 10'h13C, 3'b101, 8'h83, 17, 40'hA5023C0105, 2'b01, 0, 1};
        vt[3] = '{10'h3FF, 10'h000, 3'b010, 8'h82, 40, 40'hFF03000002, 2'b10, 1, 0};
        vt[4] = '{10'h1C3, 10'h2E7, 3'b111, 8'h80, 48, 40'hC301E70207, 2'b00, 1, 0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_miso", {47'b0, miso}, {47'b0, MISO_IDLE});
        chk("reset_leds", {46'b0, leds}, 48'd0);
        chk("reset_pulses", {46'b0, frame_done, frame_err}, 48'd0);
        clr_n = 1'b1;
        hw();

        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vt[i]);

        // Snapshot: x changes at bit 3, frame must still report the old value.
        x_pos = 10'h000; y_pos = 10'h000; buttons = 3'b000;
        frame(40, 8'h81, 3, 1, rx);
        chk("snap_first", rx, 48'h00_0000000000);
        chk("snap_leds", {46'b0, leds}, 48'd1);
        frame(40, 8'h81, -1, 0, rx);
        chk("snap_next", rx, 48'h00_FF03000000);

        // Reset at bit 20 with ss held low; the rest of the frame is ignored.
        d0 = done_cnt; e0 = err_cnt;
        frame(40, 8'h82, 20, 2, rx);
        chk("rstmid_leds", {46'b0, leds}, 48'd0);
        chk("rstmid_pulses", 48'((done_cnt - d0) + (err_cnt - e0)), 48'd0);
        chk("rstmid_miso", {47'b0, miso}, {47'b0, MISO_IDLE});
        x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
        d0 = done_cnt;
        frame(40, 8'h83, -1, 0, rx);
        chk("after_rst_data", rx, 48'h00_A5023C0105);
        chk("after_rst_leds", {46'b0, leds}, 48'd3);
        chk("after_rst_done", 48'(done_cnt - d0), 48'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jstk_spi_responder.md
# jstk_spi_responder

- SPI slave that emulates the PmodJSTK joystick module, i.e. the responder end of the joystick SPI link.
- Answers the 5-byte PmodJSTK frame with X, Y and button data taken from its input ports, and decodes the master's command byte to drive the two LED bits.
- Used as a drop-in joystick stand-in for bench and board bring-up of the Pong joystick path, on a second board or inside the simulation top beside the SPI master.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on sclk/ss/mosi; legal values 2..3.

Ports:
- clk  in  1  system clock; must be ≥ 8× the SCLK frequency.
- clr_n  in  1  asynchronous, active-low reset.
- x_pos  in  10  X position to report.
- y_pos  in  10  Y position to report.
- buttons  in  3  {btn2, btn1, jstk_btn}.
- sclk  in  1  SPI clock from master; SPI mode 0.
- ss  in  1  slave select, active low.
- mosi  in  1  master data out.
- miso  out  1  slave data out.
- leds  out  2  LED bits from the last valid command byte.
- frame_done  out  1  one-cycle pulse when a complete 40-bit frame ends.
- frame_err  out  1  one-cycle pulse when ss rises after 1..39 bits.

## Operation
- Input synchronization:
  - sclk, ss and mosi each pass through SYNC_STAGES flops.
  - The sclk and ss synchronizers reset to 0; the mosi synchronizer resets to 0.
  - A further flop per line provides rise/fall edge detection.
- States: WAIT, IDLE, ACTIVE.
  - WAIT (the reset state): stays here until synced ss = 1, then moves to IDLE. This prevents joining a frame mid-way.
  - IDLE: on ss fall, snapshot the inputs, load tx_sh, clear bit_cnt and go to ACTIVE.
  - ACTIVE: on ss rise, go to IDLE.
- Snapshot and tx_sh load, in transmit order, MSB first:
  - {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, buttons}.
  - Inputs are captured only at ss fall, so a frame is always internally consistent.
- Shifting in ACTIVE:
  - sclk rise: shift mosi into rx_sh[7:0]. While bit_cnt < 8, this builds cmd. bit_cnt increments and saturates at 40.
  - sclk fall: shift tx_sh left by one. miso = tx_sh[39] while bit_cnt < 40, else 0.
  - The first bit is valid on miso before the first sclk rise.
- On ss rise in ACTIVE:
  - bit_cnt == 40: pulse frame_done. If cmd[7:2] == 6'b100000, set leds <= cmd[1:0]; otherwise leds are unchanged.
  - bit_cnt 1..39: pulse frame_err; leds unchanged.
  - bit_cnt == 0: no pulse.
- Extra sclk edges beyond 40 bits: no effect on cmd or leds; miso held 0.
- In WAIT or IDLE, miso follows the Configuration rule.

## Timing
- Reset values: miso 0 (Z under JSTK_RESP_TRISTATE_EN), leds 2'b00, frame_done 0, frame_err 0, state WAIT, bit_cnt 0, tx_sh 0.
- Edge detection latency is SYNC_STAGES+1 clk after the pin changes.
- miso changes SYNC_STAGES+1 clk after a sclk fall, or after the ss fall for the first bit.
- frame_done, frame_err and the leds update occur in the same cycle, SYNC_STAGES+1 clk after the ss rise.
- Reset mid-frame:
  - Aborts the frame immediately with no pulse and leds reset.
  - After release the block re-enters WAIT and ignores the frame still in progress.
- If ss rise and sclk edge are detected in the same cycle, ss rise wins and the sclk edge is ignored.

## Configuration
- JSTK_RESP_TRISTATE_EN defined: miso = 1'bz in WAIT and IDLE, and during reset.
- JSTK_RESP_TRISTATE_EN undefined: miso is driven 0 in those states.
- ACTIVE behaviour is identical in both builds.

## Test plan
- Full frame:
  - Stimulus: x_pos=10'h2A5, y_pos=10'h13C, buttons=3'b101; master sends 8'h81 then 32 zero bits at clk/16.
  - Required: MISO bytes A5, 02, 3C, 01, 05; frame_done pulses once; leds=2'b01.
- Invalid command:
  - Stimulus: command 8'h43 over a full frame.
  - Required: frame_done pulses; leds unchanged from the previous 2'b01.
- Short frame:
  - Stimulus: ss raised after 17 bits.
  - Required: frame_err pulses once, no frame_done, leds unchanged.
  - Next full frame with 8'h82 returns correct data and sets leds=2'b10.
- Snapshot:
  - Stimulus: change x_pos from 10'h000 to 10'h3FF at bit 3 of the frame.
  - Required: MISO shows 00, 00 for the X bytes; the next frame shows FF, 03.
- Reset mid-frame:
  - Stimulus: assert clr_n=0 at bit 20 with ss held low, release, keep clocking, then raise ss.
  - Required: leds=2'b00, no frame_done/frame_err for that frame, miso 0 (Z with macro).
  - The next full frame works normally.
- Overrun:
  - Stimulus: 48 sclk cycles in one frame.
  - Required: bits 41..48 on miso are 0; frame_done pulses once; leds taken from the first byte.
